// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : UART receiver for frames of start(0), N data bits MSB first,
//             one odd-parity bit and one stop(1). The asynchronous rx line is
//             double-flopped and every bit is sampled at mid-bit. Received
//             words are presented on a one-entry valid/ready output buffer
//             together with parity/framing status.
//  Ports    : clk            system clock, rising edge
//             rst_n          asynchronous active-low reset
//             rx             serial input (asynchronous, idles high)
//             rx_data        received word, MSB = first data bit on the line
//             rx_parity_err  parity check failed for the word in rx_data
//             rx_frame_err   stop bit was sampled low for the word in rx_data
//             rx_valid       rx_data and status bits are valid
//             rx_ready       consumer accepts when rx_valid & rx_ready
//             rx_overrun     one-cycle pulse: a completed frame was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    output logic [N-1:0] rx_data,
    output logic         rx_parity_err,
    output logic         rx_frame_err,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         rx_overrun
);

    localparam int c_TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int c_CNT_W   = $clog2(N + 1);

    localparam logic [c_TIMER_W-1:0] c_T_HALF   = c_TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TIMER_W-1:0] c_T_FULL   = c_TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]   c_LAST_BIT = c_CNT_W'(N - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_START     = 3'd1;
    localparam logic [2:0] c_S_DATA      = 3'd2;
    localparam logic [2:0] c_S_PARITY    = 3'd3;
    localparam logic [2:0] c_S_STOP      = 3'd4;
    localparam logic [2:0] c_S_WAIT_HIGH = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [2:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [N-1:0]         r_shift;
    logic                 r_perr;
    logic                 w_tick;

    // Full-bit sample point, used once the start bit has been centred on.
    assign w_tick = (r_timer == c_T_FULL);

    // Synchroniser resets to the idle (high) level so reset never fakes a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_S_IDLE;
            r_timer       <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_perr        <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;

            // Consumer handshake; a frame completing in the same cycle
            // reloads the buffer below and overrides this clear.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (!r_rxs) begin
                        r_state <= c_S_START;
                        r_timer <= '0;
                    end
                end

                c_S_START: begin
                    if (r_timer == c_T_HALF) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        // Line already back high at mid-bit: a glitch.
                        r_state   <= r_rxs ? c_S_IDLE : c_S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                c_S_DATA: begin
                    r_timer <= w_tick ? '0 : r_timer + 1'b1;
                    if (w_tick) begin
                        r_shift <= N'({r_shift, r_rxs});
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_S_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                c_S_PARITY: begin
                    r_timer <= w_tick ? '0 : r_timer + 1'b1;
                    if (w_tick) begin
                        // Odd parity: data plus parity must hold an odd number of ones.
                        r_perr  <= ~((^r_shift) ^ r_rxs);
                        r_state <= c_S_STOP;
                    end
                end

                c_S_STOP: begin
                    r_timer <= w_tick ? '0 : r_timer + 1'b1;
                    if (w_tick) begin
                        if (!rx_valid || rx_ready) begin
                            rx_data       <= r_shift;
                            rx_parity_err <= r_perr;
                            rx_frame_err  <= ~r_rxs;
                            rx_valid      <= 1'b1;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                        // A low stop bit may be a break; wait for the line
                        // to go high before hunting for the next start.
                        r_state <= r_rxs ? c_S_IDLE : c_S_WAIT_HIGH;
                    end
                end

                c_S_WAIT_HIGH: begin
                    if (r_rxs) begin
                        r_state <= c_S_IDLE;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Self-checking bench for uart_rx_core. Frames are driven bit by
//             bit; a frame-level model predicts when each word lands in the
//             output buffer and what it contains, and a per-cycle compare
//             process checks the DUT against that model. Directed literal
//             checks pin latency, error flags, overrun and reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int N   = 8;
    localparam int CPB = 16;
    // Edges from driving the start bit to rx_valid high: 2 synchroniser
    // cycles, then stop sampled at T0 + CPB/2 + (N+2)*CPB, valid one later.
    localparam int FRAME_LAT = 2 + CPB / 2 + (N + 2) * CPB + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx;
    logic         rx_ready;
    logic [N-1:0] rx_data;
    logic         rx_parity_err;
    logic         rx_frame_err;
    logic         rx_valid;
    logic         rx_overrun;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int n_vcyc = 0;
    int n_ovr  = 0;

    typedef struct {
        int           due;
        logic [N-1:0] d;
        logic         pe;
        logic         fe;
    } exp_t;

    exp_t pend[$];

    logic         m_valid = 1'b0;
    logic [N-1:0] m_data  = '0;
    logic         m_pe    = 1'b0;
    logic         m_fe    = 1'b0;
    logic         m_ovr   = 1'b0;

    uart_rx_core #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level model: one-entry buffer fed by frames at their due edge.
    initial begin : model
        exp_t f;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_valid = 1'b0; m_data = '0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
                pend.delete();
            end else begin
                m_ovr = 1'b0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    f = pend.pop_front();
                    if (!m_valid || rx_ready) begin
                        m_valid = 1'b1; m_data = f.d; m_pe = f.pe; m_fe = f.fe;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && rx_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("valid", rx_valid, m_valid);
                chk("overrun", rx_overrun, m_ovr);
                if (m_valid) begin
                    chk("data", rx_data, m_data);
                    chk("parity_err", rx_parity_err, m_pe);
                    chk("frame_err", rx_frame_err, m_fe);
                end
                if (rx_valid) n_vcyc++;
                if (rx_overrun) n_ovr++;
            end
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic bit_out(input logic b, input int cycles);
        rx = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic p, input logic s);
        exp_t e;
        e.due = cyc + FRAME_LAT;
        e.d   = d;
        e.pe  = (($countones(d) + int'(p)) % 2) == 0;
        e.fe  = !s;
        pend.push_back(e);
        bit_out(1'b0, CPB);
        for (int i = N - 1; i >= 0; i--) bit_out(d[i], CPB);
        bit_out(p, CPB);
        bit_out(s, CPB);
    endtask

    // Sends a frame with rx_ready high and pins the exact valid window.
    task automatic frame_check(input string name, input logic [N-1:0] d, input logic p,
                               input logic s, input logic [N-1:0] ed, input logic epe,
                               input logic efe);
        fork
            send_frame(d, p, s);
            begin
                repeat (FRAME_LAT - 1) @(posedge clk);
                @(negedge clk);
                chk({name, "_valid_early"}, rx_valid, 1'b0);
                @(posedge clk);
                @(negedge clk);
                chk({name, "_valid"}, rx_valid, 1'b1);
                chk({name, "_data"}, rx_data, ed);
                chk({name, "_perr"}, rx_parity_err, epe);
                chk({name, "_ferr"}, rx_frame_err, efe);
                @(posedge clk);
                @(negedge clk);
                chk({name, "_valid_one_cycle"}, rx_valid, 1'b0);
            end
        join
    endtask

    initial begin : stim
        int           vb;
        int           ob;
        logic [N-1:0] pd;
        rst_n = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_perr", rx_parity_err, 1'b0);
        chk("rst_ferr", rx_frame_err, 1'b0);
        chk("rst_overrun", rx_overrun, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_no_valid", n_vcyc, 0);

        // Good frame: 0xA5 has four ones, so parity 1 is correct.
        frame_check("a5", 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        bit_out(1'b1, 20);

        // 0x3C has four ones: parity 0 is wrong, parity 1 is right.
        frame_check("perr", 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        bit_out(1'b1, 20);
        frame_check("par_ok", 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        bit_out(1'b1, 20);

        // Low stop bit followed by a held-low line must not start a new frame.
        frame_check("ferr", 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1);
        vb = n_vcyc;
        bit_out(1'b0, 40);
        bit_out(1'b1, 250);
        chk("break_no_rerx", n_vcyc, vb);

        // Glitch shorter than half a bit.
        vb = n_vcyc;
        bit_out(1'b0, 5);
        bit_out(1'b1, 100);
        chk("glitch_no_valid", n_vcyc, vb);
        frame_check("after_glitch", 8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
        bit_out(1'b1, 20);

        // Backpressure: second back-to-back word is dropped with one pulse.
        rx_ready = 1'b0;
        ob = n_ovr;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        bit_out(1'b1, 10);
        chk("bp_hold_data", rx_data, 8'h11);
        chk("bp_hold_valid", rx_valid, 1'b1);
        chk("bp_overrun_count", n_ovr - ob, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        bit_out(1'b1, 10);
        chk("bp_drained", rx_valid, 1'b0);

        // Accept in exactly the cycle the next frame completes.
        ob = n_ovr;
        send_frame(8'h11, 1'b1, 1'b1);
        bit_out(1'b1, 10);
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                repeat (FRAME_LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        bit_out(1'b1, 10);
        chk("simul_data", rx_data, 8'h22);
        chk("simul_valid", rx_valid, 1'b1);
        chk("simul_no_overrun", n_ovr - ob, 0);

        // Reset in the middle of data bit 4 while a word is held.
        chk("pre_rst_valid", rx_valid, 1'b1);
        pd = 8'hC3;
        bit_out(1'b0, CPB);
        for (int i = N - 1; i >= N - 4; i--) bit_out(pd[i], CPB);
        rx = pd[N-5];
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_perr", rx_parity_err, 1'b0);
        chk("midrst_ferr", rx_frame_err, 1'b0);
        chk("midrst_overrun", rx_overrun, 1'b0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_ready = 1'b1;
        bit_out(1'b1, 20);
        frame_check("post_rst", 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        bit_out(1'b1, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
